// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C SCL timing controller.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PH0       = 3'd1,
    ST_PH1       = 3'd2,
    ST_PH2       = 3'd3,
    ST_PH3       = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } scl_state_e;

  localparam logic [1:0] PHASE_Q0 = 2'd0;
  localparam logic [1:0] PHASE_Q1 = 2'd1;
  localparam logic [1:0] PHASE_Q2 = 2'd2;
  localparam logic [1:0] PHASE_Q3 = 2'd3;

  localparam int MIN_RATIO_DEF   = 2;
  localparam int TIMEOUT_CYC_DEF = 4096;

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchronizer for the open-drain bus lines (SCL, SDA).
// O_q_nxt exposes the first stage, i.e. the value O_q takes on the next edge.
module i2c_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic I_ref_clk,
  input  logic I_rst,
  input  logic I_d,
  output logic O_q,
  output logic O_q_nxt
);

  logic meta_q;

  always_ff @(posedge I_ref_clk or posedge I_rst) begin
    if (I_rst) begin
      meta_q <= RST_VAL;
      O_q    <= RST_VAL;
    end else begin
      meta_q <= I_d;
      O_q    <= meta_q;
    end
  end

  assign O_q_nxt = meta_q;

endmodule

// File: rtl/i2c_scl_ctrl.sv
// SCL sequencer: four quarter-phases per period, sample/change strobes, stretch wait.
// Optional stretch timeout is enabled by defining I2C_SCL_STRETCH_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | SCL released, waiting for I_run
// PH0          | SCL released, first high quarter (sample at end)
// PH1          | SCL released, second high quarter
// PH2          | SCL driven low, first low quarter (change at end)
// PH3          | SCL driven low, second low quarter (period done at end)
// WAIT_HIGH    | SCL released, waiting for the bus to read high
module i2c_scl_ctrl
  import i2c_pkg::*;
#(
  parameter int RATIO_W     = 11,
  parameter int MIN_RATIO   = MIN_RATIO_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               I_ref_clk,
  input  logic               I_rst,
  input  logic               I_cfg_wr,
  input  logic [RATIO_W-1:0] I_cfg_ratio,
  input  logic               I_run,
  input  logic               I_scl_in,
  output logic               O_scl_drv_low,
  output logic               O_busy,
  output logic [1:0]         O_phase,
  output logic               O_sample_tick,
  output logic               O_change_tick,
  output logic               O_period_done,
  output logic               O_cfg_err,
  output logic               O_timeout
);

  localparam logic [RATIO_W-1:0] MIN_R = RATIO_W'(MIN_RATIO);
  localparam logic [RATIO_W-1:0] ONE_R = RATIO_W'(1);

  scl_state_e         state_q, state_d;
  logic [RATIO_W-1:0] shadow_q, ratio_q, cnt_q;
  logic               drv_low_q, cfg_err_q;
  logic               scl_s, scl_s_nxt;
  logic               qtr_end, load_ratio, in_quarter, timeout;

  i2c_sync2 #(.RST_VAL(1'b1)) u_scl_sync (
    .I_ref_clk (I_ref_clk),
    .I_rst     (I_rst),
    .I_d       (I_scl_in),
    .O_q       (scl_s),
    .O_q_nxt   (scl_s_nxt)
  );

  assign in_quarter = (state_q == ST_PH0) || (state_q == ST_PH1) ||
                      (state_q == ST_PH2) || (state_q == ST_PH3);
  assign qtr_end    = in_quarter && (cnt_q == ratio_q);

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  localparam int STR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [STR_W-1:0] str_q;

  // Down-counter reloaded outside WAIT_HIGH; zero marks the last allowed stretch cycle.
  always_ff @(posedge I_ref_clk or posedge I_rst) begin
    if (I_rst)                         str_q <= STR_W'(TIMEOUT_CYC - 1);
    else if (state_q != ST_WAIT_HIGH)  str_q <= STR_W'(TIMEOUT_CYC - 1);
    else if (str_q != '0)              str_q <= str_q - STR_W'(1);
  end

  assign timeout = (state_q == ST_WAIT_HIGH) && (str_q == '0);
`else
  assign timeout = 1'b0;
`endif

  // WAIT_HIGH exits on the edge where scl_s rises, so PH0 starts with scl_s already high.
  always_comb begin
    state_d    = state_q;
    load_ratio = 1'b0;
    case (state_q)
      ST_IDLE: if (I_run) begin
        state_d    = ST_PH0;
        load_ratio = 1'b1;
      end
      ST_PH0: if (qtr_end) state_d = ST_PH1;
      ST_PH1: if (qtr_end) state_d = ST_PH2;
      ST_PH2: if (qtr_end) state_d = ST_PH3;
      ST_PH3: if (qtr_end) begin
        state_d    = ST_WAIT_HIGH;
        load_ratio = 1'b1;
      end
      ST_WAIT_HIGH: begin
        if (timeout)        state_d = ST_IDLE;
        else if (scl_s_nxt) state_d = I_run ? ST_PH0 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_ref_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= ONE_R;
      shadow_q  <= MIN_R;
      ratio_q   <= MIN_R;
      drv_low_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= (in_quarter && !qtr_end) ? cnt_q + ONE_R : ONE_R;
      drv_low_q <= (state_d == ST_PH2) || (state_d == ST_PH3);
      cfg_err_q <= I_cfg_wr && (I_cfg_ratio < MIN_R);
      if (I_cfg_wr && (I_cfg_ratio >= MIN_R)) shadow_q <= I_cfg_ratio;
      if (load_ratio) ratio_q <= shadow_q;
    end
  end

  always_comb begin
    O_phase = PHASE_Q0;
    case (state_q)
      ST_PH1:       O_phase = PHASE_Q1;
      ST_PH2:       O_phase = PHASE_Q2;
      ST_PH3:       O_phase = PHASE_Q3;
      ST_WAIT_HIGH: O_phase = PHASE_Q3;
      default:      O_phase = PHASE_Q0;
    endcase
  end

  assign O_scl_drv_low = drv_low_q;
  assign O_busy        = (state_q != ST_IDLE);
  assign O_sample_tick = qtr_end && (state_q == ST_PH0);
  assign O_change_tick = qtr_end && (state_q == ST_PH2);
  assign O_period_done = qtr_end && (state_q == ST_PH3);
  assign O_cfg_err     = cfg_err_q;
  assign O_timeout     = timeout;

endmodule
